// File: rtl/alarm_system.sv
// alarm_system: debounced intrusion alarm FSM; selsw is the registered state code.
// Optional ALARM_LATCH_EN makes ALARM sticky until reset.
module alarm_system #(
  parameter int CONFIRM_CNT     = 3,
  parameter int HOLD_CYCLES     = 4,
  parameter int COOLDOWN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  output logic [2:0] selsw
);
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    DETECT = 3'b001,
    ALARM  = 3'b011,
    HOLD   = 3'b010,
    COOL   = 3'b110
  } state_t;
  localparam logic [7:0] C_LAST = 8'(CONFIRM_CNT - 1);
  localparam logic [7:0] H_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] D_LAST = 8'(COOLDOWN_CYCLES - 1);
  state_t     r_state;
  logic [7:0] r_cnt;
  assign selsw = r_state;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (x) begin
          r_state <= (CONFIRM_CNT == 1) ? ALARM : DETECT;
          r_cnt   <= (CONFIRM_CNT == 1) ? 8'd0 : 8'd1;
        end
        DETECT: if (!x) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end else if (r_cnt == C_LAST) begin
          r_state <= ALARM;
          r_cnt   <= '0;
        end else r_cnt <= r_cnt + 8'd1;
`ifdef ALARM_LATCH_EN
        ALARM: r_cnt <= '0;
`else
        ALARM: if (!x) begin
          r_state <= (HOLD_CYCLES == 1) ? COOL : HOLD;
          r_cnt   <= (HOLD_CYCLES == 1) ? 8'd0 : 8'd1;
        end
`endif
        HOLD: if (x) begin
          r_state <= ALARM;
          r_cnt   <= '0;
        end else if (r_cnt == H_LAST) begin
          r_state <= COOL;
          r_cnt   <= '0;
        end else r_cnt <= r_cnt + 8'd1;
        COOL: if (r_cnt == D_LAST) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end else r_cnt <= r_cnt + 8'd1;
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alarm_system.sv
// tb_alarm_system: scoreboard bench for alarm_system with default parameters.
module tb_alarm_system;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0;
  logic [2:0] selsw;
  logic [2:0] q_exp[$];
  int         n_tests = 0;
  int         n_fail = 0;
  alarm_system dut (.clk(clk), .reset(reset), .x(x), .selsw(selsw));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic xi, input logic [2:0] exp);
    reset = r;
    x = xi;
    q_exp.push_back(exp);
    @(posedge clk);
    #1;
    if (q_exp.size() == 0) check({tag, "_empty"}, selsw, 3'bxxx);
    else check(tag, selsw, q_exp.pop_front());
  endtask
  initial begin
    @(posedge clk);
    #1;
    step("reset", 1, 0, 3'b000);
    for (int i = 0; i < 20; i++) step("idle", 0, 0, 3'b000);
`ifdef ALARM_LATCH_EN
    step("lat_d1", 0, 1, 3'b001);
    step("lat_d2", 0, 1, 3'b001);
    step("lat_al", 0, 1, 3'b011);
    for (int i = 0; i < 10; i++) step("lat_hold", 0, 0, 3'b011);
    step("lat_rst", 1, 0, 3'b000);
`else
    step("brk_d1", 0, 1, 3'b001);
    step("brk_d2", 0, 1, 3'b001);
    step("brk_i1", 0, 0, 3'b000);
    step("brk_d3", 0, 1, 3'b001);
    step("brk_d4", 0, 1, 3'b001);
    step("brk_i2", 0, 0, 3'b000);
    step("cyc_d1", 0, 1, 3'b001);
    step("cyc_d2", 0, 1, 3'b001);
    step("cyc_al", 0, 1, 3'b011);
    step("cyc_h1", 0, 0, 3'b010);
    step("cyc_h2", 0, 0, 3'b010);
    step("cyc_h3", 0, 0, 3'b010);
    step("cyc_c1", 0, 0, 3'b110);
    step("cyc_c2", 0, 0, 3'b110);
    step("cyc_i", 0, 0, 3'b000);
    step("rt_d1", 0, 1, 3'b001);
    step("rt_d2", 0, 1, 3'b001);
    step("rt_al", 0, 1, 3'b011);
    step("rt_h1", 0, 0, 3'b010);
    step("rt_h2", 0, 0, 3'b010);
    step("rt_al2", 0, 1, 3'b011);
    step("rt_stay", 0, 1, 3'b011);
    step("rt3_h1", 0, 0, 3'b010);
    step("rt3_h2", 0, 0, 3'b010);
    step("rt3_h3", 0, 0, 3'b010);
    step("rt3_al", 0, 1, 3'b011);
    step("cx_h1", 0, 0, 3'b010);
    step("cx_h2", 0, 0, 3'b010);
    step("cx_h3", 0, 0, 3'b010);
    step("cx_c1", 0, 0, 3'b110);
    step("cx_c2", 0, 1, 3'b110);
    step("cx_i", 0, 1, 3'b000);
    step("cx_idle", 0, 0, 3'b000);
`endif
    step("mr_d1", 0, 1, 3'b001);
    step("mr_d2", 0, 1, 3'b001);
    step("mr_rst", 1, 1, 3'b000);
    step("fr_d1", 0, 1, 3'b001);
    step("fr_d2", 0, 1, 3'b001);
    step("fr_al", 0, 1, 3'b011);
    step("fr_rst", 1, 0, 3'b000);
    reset = 1'b0;
    for (int i = 0; i < 500; i++) begin
      x = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("legal", 3'(selsw inside {3'b000, 3'b001, 3'b011, 3'b010, 3'b110}), 3'b001);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
